// File: rtl/bicubic_tap_blend.sv
// bicubic_tap_blend
//   Final stage of the bicubic weight path: blends four aligned pixel taps with
//   four Q1.8 tap weights, per colour channel.
//   The weighted sum is p1*w1 + p2*w2 - p0*w0 - p3*w3.
//   It is rounded (+0.5 LSB), shifted down by FRAC, clamped to [0, 2^DW-1],
//   and registered onto m_data.
//   The four-stage valid/ready pipeline runs one beat per cycle and has a
//   latency of 4 cycles. Empty stages absorb upstream data even while the
//   output is stalled.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    input handshake; w0..w3 and p0..p3 sampled on accept
//   w0..w3             unsigned tap weight magnitudes (256 = 1.0)
//   p0..p3             tap pixels, CH channels of DW bits, channel 0 in LSBs
//   m_valid/m_ready    output handshake
//   m_data             blended pixel, same channel packing as the taps
//   clamp_cnt          saturating count of output beats in which any channel
//                      clamped (present only with BICUBIC_CLAMP_CNT_EN)
//
// Build option: define BICUBIC_CLAMP_CNT_EN to add clamp_cnt.
module bicubic_tap_blend #(
    parameter int DW   = 8,
    parameter int CH   = 3,
    parameter int WW   = 9,
    parameter int FRAC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WW-1:0]      w0,
    input  logic [WW-1:0]      w1,
    input  logic [WW-1:0]      w2,
    input  logic [WW-1:0]      w3,
    input  logic [CH*DW-1:0]   p0,
    input  logic [CH*DW-1:0]   p1,
    input  logic [CH*DW-1:0]   p2,
    input  logic [CH*DW-1:0]   p3,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [CH*DW-1:0]   m_data
`ifdef BICUBIC_CLAMP_CNT_EN
    ,
    output logic [15:0]        clamp_cnt
`endif
);

    localparam int PW = DW + WW;      // product width
    localparam int SW = PW + 1;       // pos/neg sum width
    localparam int AW = SW + 1;       // signed accumulator width
    localparam logic signed [AW-1:0] RND     = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] PIX_MAX = {{(AW-DW){1'b0}}, {DW{1'b1}}};

    logic v1, v2, v3, v4;
    logic ld1, ld2, ld3, ld4;

    logic [PW-1:0]        prod_q [CH][4];
    logic [SW-1:0]        pos_q  [CH];
    logic [SW-1:0]        neg_q  [CH];
    logic signed [AW-1:0] acc_q  [CH];
    logic signed [AW-1:0] shifted [CH];
    logic [CH*DW-1:0]     res_d;
    logic                 clamp_d;

    // A stage may load when it is empty or its contents move on this cycle,
    // so bubbles collapse even while the output is held.
    assign ld4     = !v4 || m_ready;
    assign ld3     = !v3 || ld4;
    assign ld2     = !v2 || ld3;
    assign ld1     = !v1 || ld2;
    assign s_ready = ld1;
    assign m_valid = v4;

    function automatic logic [PW-1:0] mul(input logic [DW-1:0] p, input logic [WW-1:0] w);
        return {{WW{1'b0}}, p} * {{DW{1'b0}}, w};
    endfunction

    // S1: unsigned tap products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int unsigned c = 0; c < CH; c++)
                for (int unsigned k = 0; k < 4; k++)
                    prod_q[c][k] <= '0;
        end else if (ld1) begin
            v1 <= s_valid;
            for (int unsigned c = 0; c < CH; c++) begin
                prod_q[c][0] <= mul(p0[c*DW +: DW], w0);
                prod_q[c][1] <= mul(p1[c*DW +: DW], w1);
                prod_q[c][2] <= mul(p2[c*DW +: DW], w2);
                prod_q[c][3] <= mul(p3[c*DW +: DW], w3);
            end
        end
    end

    // S2: split into positive (inner) and negative (outer) lobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            for (int unsigned c = 0; c < CH; c++) begin
                pos_q[c] <= '0;
                neg_q[c] <= '0;
            end
        end else if (ld2) begin
            v2 <= v1;
            for (int unsigned c = 0; c < CH; c++) begin
                pos_q[c] <= {1'b0, prod_q[c][1]} + {1'b0, prod_q[c][2]};
                neg_q[c] <= {1'b0, prod_q[c][0]} + {1'b0, prod_q[c][3]};
            end
        end
    end

    // S3: signed difference with the rounding half-LSB folded in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            for (int unsigned c = 0; c < CH; c++)
                acc_q[c] <= '0;
        end else if (ld3) begin
            v3 <= v2;
            for (int unsigned c = 0; c < CH; c++)
                acc_q[c] <= $signed({1'b0, pos_q[c]}) - $signed({1'b0, neg_q[c]}) + RND;
        end
    end

    // S4 combinational part: arithmetic shift then clamp to pixel range
    always_comb begin
        res_d   = '0;
        clamp_d = 1'b0;
        for (int unsigned c = 0; c < CH; c++) begin
            shifted[c] = acc_q[c] >>> FRAC;
            if (shifted[c][AW-1]) begin
                res_d[c*DW +: DW] = '0;
                clamp_d           = 1'b1;
            end else if (shifted[c] > PIX_MAX) begin
                res_d[c*DW +: DW] = '1;
                clamp_d           = 1'b1;
            end else begin
                res_d[c*DW +: DW] = shifted[c][DW-1:0];
            end
        end
    end

`ifdef BICUBIC_CLAMP_CNT_EN
    logic clamp_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v4     <= 1'b0;
            m_data <= '0;
`ifdef BICUBIC_CLAMP_CNT_EN
            clamp_q <= 1'b0;
`endif
        end else if (ld4) begin
            v4     <= v3;
            m_data <= res_d;
`ifdef BICUBIC_CLAMP_CNT_EN
            clamp_q <= clamp_d && v3;
`endif
        end
    end

`ifdef BICUBIC_CLAMP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clamp_cnt <= '0;
        else if (v4 && m_ready && clamp_q && (clamp_cnt != 16'hFFFF))
            clamp_cnt <= clamp_cnt + 16'd1;
    end
`else
    // Clamp flag is only consumed by the optional counter.
    logic unused_clamp;
    assign unused_clamp = clamp_d;
`endif

endmodule
